sin_phase_gen: RTL and testbench

- Phase-word source (NCO) driving the `phase`/`valid_i` input of the quadratic sine/cosine interpolator.
- Generates a 47-bit phase sequence with programmable frequency, linear chirp, phase offset, sample-rate divider and burst length.
- Has a start/stop state machine, so a single command produces a full tone or chirp burst for the downstream pipeline.

---
 rtl/sin_phase_gen.sv | 128 ++++++++++++
 tb/tb_sin_phase_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sin_phase_gen.sv
// rtl/sin_phase_gen.sv - NCO phase-word burst generator with chirp, offset and rate divider
module sin_phase_gen #(
    parameter int unsigned PHASE_BITS = 47,
    parameter int unsigned CNT_BITS   = 32,
    parameter int unsigned DIV_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [PHASE_BITS-1:0] freq_i,
    input  logic [PHASE_BITS-1:0] chirp_i,
    input  logic [PHASE_BITS-1:0] offset_i,
    input  logic [CNT_BITS-1:0]   nsamp_i,
    input  logic [DIV_BITS-1:0]   div_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  valid_o,
    output logic [PHASE_BITS-1:0] phase_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [DIV_BITS-1:0] DIV_ONE = DIV_BITS'(1);

    state_t                  state, state_n;
    logic [PHASE_BITS-1:0]   chirp_r, chirp_n;
    logic [PHASE_BITS-1:0]   offset_r, offset_n;
    logic [PHASE_BITS-1:0]   acc, acc_n;
    logic [PHASE_BITS-1:0]   inc, inc_n;
    logic [CNT_BITS-1:0]     nsamp_r, nsamp_n;
    logic [CNT_BITS-1:0]     cnt, cnt_n;
    logic [DIV_BITS-1:0]     div_r, div_n;
    logic [DIV_BITS-1:0]     divcnt, divcnt_n;
    logic                    busy_n, done_n, valid_n;
    logic [PHASE_BITS-1:0]   phase_n;
    logic                    sample_due, burst_last;

    assign sample_due = (divcnt == div_r);
    // nsamp_r == 0 is continuous mode: cnt wraps and never ends the burst
    assign burst_last = (nsamp_r != '0) && ((cnt + CNT_ONE) == nsamp_r);

    always_comb begin
        state_n  = state;
        chirp_n  = chirp_r;
        offset_n = offset_r;
        acc_n    = acc;
        inc_n    = inc;
        nsamp_n  = nsamp_r;
        cnt_n    = cnt;
        div_n    = div_r;
        divcnt_n = divcnt;
        done_n   = 1'b0;
        valid_n  = 1'b0;
        phase_n  = phase_o;
        case (state)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_n  = RUN;
                    chirp_n  = chirp_i;
                    offset_n = offset_i;
                    nsamp_n  = nsamp_i;
                    div_n    = div_i;
                    acc_n    = '0;
                    inc_n    = freq_i;
                    cnt_n    = '0;
                    divcnt_n = div_i;
                end
            end
            RUN: begin
                // stop wins over a sample falling due in the same cycle
                if (stop_i) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (sample_due) begin
                    valid_n  = 1'b1;
                    phase_n  = acc + offset_r;
                    acc_n    = acc + inc;
                    inc_n    = inc + chirp_r;
                    cnt_n    = cnt + CNT_ONE;
                    divcnt_n = '0;
                    if (burst_last) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end else begin
                    divcnt_n = divcnt + DIV_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == RUN);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            chirp_r  <= '0;
            offset_r <= '0;
            acc      <= '0;
            inc      <= '0;
            nsamp_r  <= '0;
            cnt      <= '0;
            div_r    <= '0;
            divcnt   <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            valid_o  <= 1'b0;
            phase_o  <= '0;
        end else begin
            state    <= state_n;
            chirp_r  <= chirp_n;
            offset_r <= offset_n;
            acc      <= acc_n;
            inc      <= inc_n;
            nsamp_r  <= nsamp_n;
            cnt      <= cnt_n;
            div_r    <= div_n;
            divcnt   <= divcnt_n;
            busy_o   <= busy_n;
            done_o   <= done_n;
            valid_o  <= valid_n;
            phase_o  <= phase_n;
        end
    end

endmodule

// File: tb/tb_sin_phase_gen.sv
// tb/tb_sin_phase_gen.sv - scoreboard bench for sin_phase_gen against a closed-form phase model
module tb_sin_phase_gen;

    logic        clk;
    logic        resetn;
    logic        start_i;
    logic        stop_i;
    logic [46:0] freq_i;
    logic [46:0] chirp_i;
    logic [46:0] offset_i;
    logic [31:0] nsamp_i;
    logic [15:0] div_i;
    logic        busy_o;
    logic        done_o;
    logic        valid_o;
    logic [46:0] phase_o;

    sin_phase_gen dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .stop_i   (stop_i),
        .freq_i   (freq_i),
        .chirp_i  (chirp_i),
        .offset_i (offset_i),
        .nsamp_i  (nsamp_i),
        .div_i    (div_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .valid_o  (valid_o),
        .phase_o  (phase_o)
    );

    // posedge k at time 10k, negedge at 10k+5
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        logic [46:0] ph;
    } samp_t;

    samp_t       sq[$];
    int          dq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [46:0] last_ph = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [46:0] rnd47();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[46:0];
    endfunction

    // sample j: offset + j*freq + chirp*j(j-1)/2, all mod 2^47
    function automatic logic [46:0] model(input logic [46:0] f, input logic [46:0] c,
                                          input logic [46:0] o, input int j);
        logic [46:0] jj, tn;
        jj = 47'(j);
        tn = 47'((longint'(j) * longint'(j - 1)) / 2);
        return o + f * jj + c * tn;
    endfunction

    always @(negedge clk) begin
        int    m;
        samp_t s;
        int    d;
        m = int'($time / 10);
        if (!resetn) begin
            last_ph = '0;
        end else begin
            if (valid_o === 1'b1) begin
                if (sq.size() == 0) begin
                    chk("valid_unexpected", 64'(valid_o), 64'd0);
                end else begin
                    s = sq.pop_front();
                    chk("valid_cycle", 64'(m), 64'(s.cyc));
                    chk("phase", 64'(phase_o), 64'(s.ph));
                end
                last_ph = phase_o;
            end else begin
                chk("phase_hold", 64'(phase_o), 64'(last_ph));
            end
            if (done_o === 1'b1) begin
                if (dq.size() == 0) begin
                    chk("done_unexpected", 64'(done_o), 64'd0);
                end else begin
                    d = dq.pop_front();
                    chk("done_cycle", 64'(m), 64'(d));
                    chk("busy_at_done", 64'(busy_o), 64'd0);
                end
            end
        end
    end

    task automatic goto(input int m);
        while ($time < 64'(10 * m + 2)) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic scramble();
        freq_i   = rnd47();
        chirp_i  = rnd47();
        offset_i = rnd47();
        nsamp_i  = $urandom;
        div_i    = 16'($urandom);
    endtask

    // called at 10k+2; start is sampled at edge k+1
    task automatic issue(input logic [46:0] f, input logic [46:0] c, input logic [46:0] o,
                         input int ns, input int dv, output int last_m);
        int k, n;
        k        = int'($time / 10);
        freq_i   = f;
        chirp_i  = c;
        offset_i = o;
        nsamp_i  = 32'(ns);
        div_i    = 16'(dv);
        start_i  = 1'b1;
        stop_i   = 1'b0;
        n        = (ns == 0) ? 64 : ns;
        for (int j = 0; j < n; j++)
            sq.push_back('{k + 2 + j * (dv + 1), model(f, c, o, j)});
        if (ns != 0) dq.push_back(k + 2 + (ns - 1) * (dv + 1));
        last_m = k + 2 + (n - 1) * (dv + 1);
        @(posedge clk);
        #2;
        start_i = 1'b0;
        scramble();
        chk("busy_after_start", 64'(busy_o), 64'd1);
    endtask

    task automatic do_stop();
        int    k;
        samp_t keep[$];
        k      = int'($time / 10);
        stop_i = 1'b1;
        foreach (sq[i]) if (sq[i].cyc <= k) keep.push_back(sq[i]);
        sq = keep;
        dq.push_back(k + 1);
        @(posedge clk);
        #2;
        stop_i = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_valid"}, 64'(valid_o), 64'd0);
        chk({tag, "_phase"}, 64'(phase_o), 64'd0);
    endtask

    initial begin
        int lm;
        resetn   = 1'b0;
        start_i  = 1'b0;
        stop_i   = 1'b0;
        freq_i   = '0;
        chirp_i  = '0;
        offset_i = '0;
        nsamp_i  = '0;
        div_i    = '0;
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        resetn = 1'b1;
        @(posedge clk);
        #2;
        chk_zero("post_reset");

        issue(47'd1 << 40, '0, '0, 4, 0, lm);
        goto(lm);
        issue(47'd1 << 40, '0, '0, 4, 2, lm);
        goto(lm);
        issue(47'd1 << 46, '0, 47'd1 << 45, 3, 0, lm);
        goto(lm);
        issue('0, 47'd1, '0, 4, 0, lm);
        goto(lm);
        issue('0, '1, '0, 4, 1, lm);
        goto(lm);
        for (int r = 0; r < 12; r++) begin
            issue(rnd47(), rnd47(), rnd47(), int'($urandom_range(1, 6)),
                  int'($urandom_range(0, 3)), lm);
            goto(lm);
        end
        goto(lm + 1);

        start_i = 1'b1;
        stop_i  = 1'b1;
        @(posedge clk);
        #2;
        start_i = 1'b0;
        stop_i  = 1'b0;
        chk("start_stop_idle_busy", 64'(busy_o), 64'd0);

        issue(47'd5, '0, rnd47(), 0, 0, lm);
        repeat (10) begin
            @(posedge clk);
            #2;
        end
        start_i = 1'b1;
        @(posedge clk);
        #2;
        start_i = 1'b0;
        do_stop();
        issue(47'd5, '0, 47'd77, 2, 0, lm);
        goto(lm + 2);

        issue(rnd47(), rnd47(), rnd47(), 20, 1, lm);
        repeat (5) begin
            @(posedge clk);
            #2;
        end
        resetn = 1'b0;
        sq.delete();
        dq.delete();
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        #2;
        resetn = 1'b1;
        issue(rnd47(), rnd47(), 47'h1234_5678_9abc, 2, 0, lm);
        goto(lm + 3);

        chk("samples_drained", 64'(sq.size()), 64'd0);
        chk("dones_drained", 64'(dq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
